// File: rtl/pwm_tick_gen.sv
// PWM generator clocked by prescaler ticks. Period/duty are loaded into shadow registers
// and become active only on a period boundary (or straight away while idle).
module pwm_tick_gen #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick,
    input  logic             enable,
    input  logic [WIDTH-1:0] cfg_period,
    input  logic [WIDTH-1:0] cfg_duty,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    output logic             pwm_out,
    output logic             period_end,
    output logic             busy
);

    localparam logic [WIDTH-1:0] One = WIDTH'(1);

    typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] act_period_q, act_period_d;
    logic [WIDTH-1:0] act_duty_q, act_duty_d;
    logic [WIDTH-1:0] sh_period_q, sh_duty_q;
    logic             shadow_pending_q, shadow_pending_d;
    logic             pwm_d, period_end_d;
    logic             xfer, last_cnt, apply;

    assign cfg_ready = ~shadow_pending_q;
    assign xfer      = cfg_valid & cfg_ready;
    assign busy      = (state_q != StIdle);
    // Guarded so act_period-1 is never evaluated for a zero period.
    assign last_cnt  = (act_period_q != '0) && (cnt_q == act_period_q - One);

    always_comb begin
        state_d          = state_q;
        cnt_d            = cnt_q;
        act_period_d     = act_period_q;
        act_duty_d       = act_duty_q;
        shadow_pending_d = shadow_pending_q;
        period_end_d     = 1'b0;
        apply            = 1'b0;

        unique case (state_q)
            StIdle: begin
                cnt_d = '0;
                if (shadow_pending_q) begin
                    apply = 1'b1;
                end else if (enable && (act_period_q != '0)) begin
                    state_d = StRun;
                end
            end
            StRun, StDrain: begin
                if (tick && last_cnt) begin
                    cnt_d        = '0;
                    period_end_d = 1'b1;
                    apply        = shadow_pending_q;
                    state_d      = enable ? StRun : StIdle;
                end else begin
                    if (tick) begin
                        cnt_d = cnt_q + One;
                    end
                    state_d = enable ? StRun : StDrain;
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase

        if (apply) begin
            act_period_d     = sh_period_q;
            act_duty_d       = sh_duty_q;
            shadow_pending_d = 1'b0;
            if (sh_period_q == '0) begin
                state_d = StIdle;
            end
        end

        // A transfer needs an empty shadow, so it never collides with an apply.
        if (xfer) begin
            shadow_pending_d = 1'b1;
        end

        pwm_d = (state_d != StIdle) && (cnt_d < act_duty_d);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q          <= StIdle;
            cnt_q            <= '0;
            act_period_q     <= '0;
            act_duty_q       <= '0;
            sh_period_q      <= '0;
            sh_duty_q        <= '0;
            shadow_pending_q <= 1'b0;
            pwm_out          <= 1'b0;
            period_end       <= 1'b0;
        end else begin
            state_q          <= state_d;
            cnt_q            <= cnt_d;
            act_period_q     <= act_period_d;
            act_duty_q       <= act_duty_d;
            shadow_pending_q <= shadow_pending_d;
            pwm_out          <= pwm_d;
            period_end       <= period_end_d;
            if (xfer) begin
                sh_period_q <= cfg_period;
                sh_duty_q   <= cfg_duty;
            end
        end
    end

endmodule

// File: tb/tb_pwm_tick_gen.sv
// Directed bench for pwm_tick_gen: reset, basic PWM, shadow timing, edge duties,
// drain/resume, reset mid-period and period 0.
module tb_pwm_tick_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic        tick;
    logic        enable;
    logic [31:0] cfg_period;
    logic [31:0] cfg_duty;
    logic        cfg_valid;
    logic        cfg_ready;
    logic        pwm_out;
    logic        period_end;
    logic        busy;

    int n_checks = 0;
    int n_err    = 0;

    pwm_tick_gen #(.WIDTH(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .tick       (tick),
        .enable     (enable),
        .cfg_period (cfg_period),
        .cfg_duty   (cfg_duty),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .pwm_out    (pwm_out),
        .period_end (period_end),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clk1();
        @(posedge clk);
        #1;
    endtask

    // Issue one config transfer in a clock without a tick.
    task automatic load(input logic [31:0] p, input logic [31:0] d);
        cfg_period = p;
        cfg_duty   = d;
        cfg_valid  = 1'b1;
        clk1();
        cfg_valid  = 1'b0;
        chk($sformatf("ready_low_after_load_%0d_%0d", p, d), cfg_ready, 1'b0);
    endtask

    // n ticks, each followed by gap idle clocks; bit i of the patterns is the expectation
    // right after tick i+1.
    task automatic run_ticks(input string tag, input int n, input int gap,
                             input logic [31:0] pwm_pat, input logic [31:0] pe_pat);
        for (int i = 0; i < n; i++) begin
            tick = 1'b1;
            clk1();
            tick = 1'b0;
            chk($sformatf("%s_pwm_t%0d", tag, i + 1), pwm_out, pwm_pat[i]);
            chk($sformatf("%s_pe_t%0d", tag, i + 1), period_end, pe_pat[i]);
            for (int g = 0; g < gap; g++) begin
                clk1();
                chk($sformatf("%s_pwm_hold_t%0d", tag, i + 1), pwm_out, pwm_pat[i]);
                chk($sformatf("%s_pe_low_t%0d", tag, i + 1), period_end, 1'b0);
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst        = 1'b1;
        tick       = 1'b1;
        enable     = 1'b0;
        cfg_period = 32'd5;
        cfg_duty   = 32'd2;
        cfg_valid  = 1'b1;

        // Reset with valid and tick held high
        repeat (3) clk1();
        chk("rst_ready", cfg_ready, 1'b1);
        chk("rst_pwm", pwm_out, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_pe", period_end, 1'b0);
        rst       = 1'b0;
        tick      = 1'b0;
        cfg_valid = 1'b0;
        enable    = 1'b1;
        clk1();
        chk("post_rst_ready", cfg_ready, 1'b1);
        clk1();
        chk("post_rst_busy", busy, 1'b0);
        enable = 1'b0;
        clk1();

        // Basic PWM 10/3, tick every 4 clocks
        enable = 1'b1;
        load(32'd10, 32'd3);
        clk1();
        chk("idle_apply_ready", cfg_ready, 1'b1);
        chk("idle_apply_busy", busy, 1'b0);
        clk1();
        chk("start_busy", busy, 1'b1);
        chk("start_pwm", pwm_out, 1'b1);
        chk("start_pe", period_end, 1'b0);
        run_ticks("basic1", 10, 3, 32'b1000000011, 32'b1000000000);
        run_ticks("basic2", 10, 3, 32'b1000000011, 32'b1000000000);

        // Shadow 8/6 loaded at tick 4 of a 10/3 period
        run_ticks("sh_pre", 4, 3, 32'b0011, 32'b0000);
        load(32'd8, 32'd6);
        run_ticks("sh_mid", 5, 3, 32'b00000, 32'b00000);
        chk("sh_ready_before_bnd", cfg_ready, 1'b0);
        run_ticks("sh_bnd", 1, 0, 32'b1, 32'b1);
        chk("sh_ready_after_bnd", cfg_ready, 1'b1);
        clk1();
        chk("sh_pe_one_wide", period_end, 1'b0);
        load(32'd10, 32'd0);
        run_ticks("p8d6", 8, 3, 32'b00011111, 32'b10000000);

        // Edge duties
        load(32'd10, 32'd10);
        run_ticks("duty0", 10, 3, 32'b1000000000, 32'b1000000000);
        load(32'd10, 32'd15);
        run_ticks("duty10", 10, 3, 32'h3ff, 32'h200);
        load(32'd1, 32'd1);
        run_ticks("duty15", 10, 3, 32'h3ff, 32'h200);
        run_ticks("p1", 6, 0, 32'b111111, 32'b111111);

        // Drain: enable drops at cnt 5
        load(32'd10, 32'd3);
        run_ticks("p1_close", 1, 3, 32'b1, 32'b1);
        run_ticks("dr_pre", 5, 3, 32'b00011, 32'b00000);
        enable = 1'b0;
        clk1();
        chk("drain_busy", busy, 1'b1);
        run_ticks("dr_fin", 5, 3, 32'b00000, 32'b10000);
        chk("drain_idle_busy", busy, 1'b0);
        chk("drain_idle_pwm", pwm_out, 1'b0);
        clk1();
        chk("drain_stays_idle", busy, 1'b0);

        // Resume: enable drops at cnt 7 and comes back while draining
        enable = 1'b1;
        clk1();
        chk("run2_busy", busy, 1'b1);
        chk("run2_pwm", pwm_out, 1'b1);
        run_ticks("run2_pre", 7, 3, 32'b0000011, 32'b0000000);
        enable = 1'b0;
        clk1();
        chk("run2_drain_busy", busy, 1'b1);
        enable = 1'b1;
        clk1();
        chk("run2_resume_busy", busy, 1'b1);
        run_ticks("run2_fin", 3, 3, 32'b100, 32'b100);
        chk("run2_no_gap_busy", busy, 1'b1);

        // Reset at cnt 6 with a shadow pending
        run_ticks("mr_pre", 6, 3, 32'b000011, 32'b000000);
        load(32'd20, 32'd5);
        rst = 1'b1;
        clk1();
        rst = 1'b0;
        chk("mr_busy", busy, 1'b0);
        chk("mr_pwm", pwm_out, 1'b0);
        chk("mr_ready", cfg_ready, 1'b1);
        chk("mr_pe", period_end, 1'b0);
        repeat (2) clk1();
        chk("mr_discarded_busy", busy, 1'b0);

        // Period 0 loaded while running
        load(32'd10, 32'd3);
        clk1();
        chk("p0_apply_ready", cfg_ready, 1'b1);
        clk1();
        chk("p0_run_busy", busy, 1'b1);
        run_ticks("p0_pre", 3, 3, 32'b011, 32'b000);
        load(32'd0, 32'd0);
        run_ticks("p0_fin", 7, 3, 32'b0000000, 32'b1000000);
        chk("p0_idle_busy", busy, 1'b0);
        repeat (3) clk1();
        chk("p0_no_restart_busy", busy, 1'b0);
        chk("p0_no_restart_pwm", pwm_out, 1'b0);
        chk("p0_ready", cfg_ready, 1'b1);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
